// File: rtl/cpu_clk_pkg.sv
// Shared state encodings for the CPU clock-enable / reset sequencer.
package cpu_clk_pkg;

    typedef enum logic [1:0] {
        S_RST  = 2'd0,
        S_HALT = 2'd1,
        S_RUN  = 2'd2,
        S_STEP = 2'd3
    } state_t;

endpackage

// File: rtl/clk_div_ch.sv
// Single clock-enable divider channel: one ce_o pulse every div_i+1 advancing cycles.
module clk_div_ch #(
    parameter int DIV_W = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             adv,
    input  logic [DIV_W-1:0] div_i,
    output logic             ce_o,
    output logic [DIV_W-1:0] d_o
);

    // >= rather than == so a ratio shrunk below the current phase pulses once and restarts
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            d_o  <= '0;
            ce_o <= 1'b0;
        end else if (adv) begin
            if (d_o >= div_i) begin
                d_o  <= '0;
                ce_o <= 1'b1;
            end else begin
                d_o  <= d_o + DIV_W'(1);
                ce_o <= 1'b0;
            end
        end else begin
            ce_o <= 1'b0;
        end
    end

endmodule

// File: rtl/cpu_clk_ctrl.sv
// CPU reset hold, run/halt/step FSM and N_CH divided clock enables with a ce[0] cycle counter.
// Optional breakpoint-on-cycle-count halt is built when CPU_CLK_BRK_EN is defined.
module cpu_clk_ctrl
    import cpu_clk_pkg::*;
#(
    parameter int N_CH    = 2,
    parameter int DIV_W   = 8,
    parameter int RST_CYC = 16,
    parameter int CNT_W   = 32
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  cmd_run,
    input  logic                  cmd_halt,
    input  logic                  cmd_step,
    input  logic [N_CH*DIV_W-1:0] div,
    input  logic [CNT_W-1:0]      brk_val,
    output logic [N_CH-1:0]       ce,
    output logic                  cpu_rst,
    output logic [1:0]            state,
    output logic                  step_done,
    output logic [CNT_W-1:0]      cyc_cnt,
    output logic                  brk_hit
);

    localparam int RW = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
    localparam logic [RW-1:0] RST_LAST = RW'(RST_CYC - 1);

    state_t                  st, st_nx;
    logic [RW-1:0]           rst_cnt;
    logic                    rst_done;
    logic                    adv, fire0, step_nx;
    logic                    brk_match, brk_set, brk_clr;
    logic [N_CH*DIV_W-1:0]   d_flat;
    logic [DIV_W-1:0]        d0;

    // A halt command freezes the dividers on the very edge it is sampled
    assign adv      = ((st == S_RUN) || (st == S_STEP)) && !cmd_halt;
    assign d0       = d_flat[DIV_W-1:0];
    assign fire0    = adv && (d0 >= div[DIV_W-1:0]);
    assign rst_done = (st == S_RST) && (rst_cnt == RST_LAST);
    assign state    = st;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        clk_div_ch #(.DIV_W(DIV_W)) u_ch (
            .CLK   (CLK),
            .RST   (RST),
            .adv   (adv),
            .div_i (div[i*DIV_W +: DIV_W]),
            .ce_o  (ce[i]),
            .d_o   (d_flat[i*DIV_W +: DIV_W])
        );
    end

`ifdef CPU_CLK_BRK_EN
    assign brk_match = fire0 && ((cyc_cnt + CNT_W'(1)) == brk_val);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            brk_hit <= 1'b0;
        else if (brk_set)
            brk_hit <= 1'b1;
        else if (brk_clr)
            brk_hit <= 1'b0;
    end
`else
    logic unused_brk;
    assign brk_match  = 1'b0;
    assign brk_hit    = 1'b0;
    assign unused_brk = ^{brk_val, brk_set, brk_clr};
`endif

    logic unused_d;
    assign unused_d = ^d_flat;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            st <= S_RST;
        else
            st <= st_nx;
    end

    always_comb begin
        st_nx   = st;
        step_nx = 1'b0;
        brk_set = 1'b0;
        brk_clr = 1'b0;
        case (st)
            S_RST: begin
                if (rst_done)
                    st_nx = S_HALT;
            end
            S_HALT: begin
                if (cmd_run) begin
                    st_nx   = S_RUN;
                    brk_clr = 1'b1;
                end else if (cmd_step) begin
                    st_nx   = S_STEP;
                    brk_clr = 1'b1;
                end
            end
            S_RUN: begin
                if (cmd_halt) begin
                    st_nx = S_HALT;
                end else if (brk_match) begin
                    st_nx   = S_HALT;
                    brk_set = 1'b1;
                end
            end
            S_STEP: begin
                if (cmd_halt) begin
                    st_nx = S_HALT;
                end else if (brk_match) begin
                    st_nx   = S_HALT;
                    step_nx = 1'b1;
                    brk_set = 1'b1;
                end else if (cmd_run) begin
                    st_nx   = S_RUN;
                    brk_clr = 1'b1;
                end else if (fire0) begin
                    st_nx   = S_HALT;
                    step_nx = 1'b1;
                end
            end
            default: st_nx = S_RST;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rst_cnt   <= '0;
            cpu_rst   <= 1'b1;
            step_done <= 1'b0;
            cyc_cnt   <= '0;
        end else begin
            step_done <= step_nx;
            if (rst_done)
                cpu_rst <= 1'b0;
            else if (st == S_RST)
                rst_cnt <= rst_cnt + RW'(1);
            if (fire0)
                cyc_cnt <= cyc_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Directed bench for cpu_clk_ctrl: reset hold, dividers, halt/resume, step, collisions, breakpoint.
module tb_cpu_clk_ctrl;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        cmd_run = 1'b0, cmd_halt = 1'b0, cmd_step = 1'b0;
    logic [15:0] div = 16'h0;
    logic [31:0] brk_val = 32'd0;
    logic [1:0]  ce;
    logic        cpu_rst;
    logic [1:0]  state;
    logic        step_done;
    logic [31:0] cyc_cnt;
    logic        brk_hit;

    int n_cmp  = 0;
    int n_fail = 0;

`ifdef CPU_CLK_BRK_EN
    localparam bit BRK = 1'b1;
`else
    localparam bit BRK = 1'b0;
`endif

    cpu_clk_ctrl #(.N_CH(2), .DIV_W(8), .RST_CYC(16), .CNT_W(32)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .cmd_run   (cmd_run),
        .cmd_halt  (cmd_halt),
        .cmd_step  (cmd_step),
        .div       (div),
        .brk_val   (brk_val),
        .ce        (ce),
        .cpu_rst   (cpu_rst),
        .state     (state),
        .step_done (step_done),
        .cyc_cnt   (cyc_cnt),
        .brk_hit   (brk_hit)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        repeat (3) tick();
        n_cmp++; if (state !== 2'd0) begin n_fail++; $display("FAIL rst_state got %0d want 0", state); end
        n_cmp++; if (cpu_rst !== 1'b1) begin n_fail++; $display("FAIL rst_cpu_rst got %b want 1", cpu_rst); end
        n_cmp++; if (ce !== 2'b00) begin n_fail++; $display("FAIL rst_ce got %b want 00", ce); end
        n_cmp++; if (cyc_cnt !== 32'd0) begin n_fail++; $display("FAIL rst_cyc got %0d want 0", cyc_cnt); end
        n_cmp++; if (step_done !== 1'b0 || brk_hit !== 1'b0) begin n_fail++; $display("FAIL rst_flags got %b%b want 00", step_done, brk_hit); end
        RST = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            tick();
            n_cmp++; if (cpu_rst !== (i < 16)) begin n_fail++; $display("FAIL hold_cpu_rst edge %0d got %b want %b", i, cpu_rst, (i < 16)); end
            n_cmp++; if (state !== ((i < 16) ? 2'd0 : 2'd1)) begin n_fail++; $display("FAIL hold_state edge %0d got %0d", i, state); end
            n_cmp++; if (ce !== 2'b00) begin n_fail++; $display("FAIL hold_ce edge %0d got %b want 00", i, ce); end
        end
    endtask

    task automatic test_divide();
        div = {8'd3, 8'd0};
        cmd_run = 1'b1; tick(); cmd_run = 1'b0;
        n_cmp++; if (state !== 2'd2 || ce !== 2'b00) begin n_fail++; $display("FAIL div_start got st=%0d ce=%b want st=2 ce=00", state, ce); end
        for (int j = 1; j <= 39; j++) begin
            tick();
            n_cmp++; if (ce !== {(j % 4 == 0), 1'b1}) begin n_fail++; $display("FAIL div_ce cycle %0d got %b want %b", j, ce, {(j % 4 == 0), 1'b1}); end
        end
        n_cmp++; if (cyc_cnt !== 32'd39) begin n_fail++; $display("FAIL div_cyc got %0d want 39", cyc_cnt); end
    endtask

    task automatic test_halt_resume();
        repeat (3) tick();
        cmd_halt = 1'b1; tick(); cmd_halt = 1'b0;
        n_cmp++; if (state !== 2'd1 || ce !== 2'b00) begin n_fail++; $display("FAIL halt_edge got st=%0d ce=%b want st=1 ce=00", state, ce); end
        for (int j = 0; j < 10; j++) begin
            tick();
            n_cmp++; if (ce !== 2'b00 || state !== 2'd1) begin n_fail++; $display("FAIL halt_idle cycle %0d got st=%0d ce=%b", j, state, ce); end
        end
        n_cmp++; if (cyc_cnt !== 32'd42) begin n_fail++; $display("FAIL halt_cyc got %0d want 42", cyc_cnt); end
        cmd_run = 1'b1; tick(); cmd_run = 1'b0;
        n_cmp++; if (state !== 2'd2 || ce !== 2'b00) begin n_fail++; $display("FAIL resume_edge got st=%0d ce=%b want st=2 ce=00", state, ce); end
        tick();
        n_cmp++; if (ce !== 2'b01) begin n_fail++; $display("FAIL resume_ce1 got %b want 01", ce); end
        tick();
        n_cmp++; if (ce !== 2'b11) begin n_fail++; $display("FAIL resume_ce2 got %b want 11", ce); end
        n_cmp++; if (cyc_cnt !== 32'd44) begin n_fail++; $display("FAIL resume_cyc got %0d want 44", cyc_cnt); end
    endtask

    task automatic test_step();
        cmd_halt = 1'b1; tick(); cmd_halt = 1'b0;
        div = {8'd3, 8'd2};
        cmd_step = 1'b1; tick(); cmd_step = 1'b0;
        n_cmp++; if (state !== 2'd3) begin n_fail++; $display("FAIL step_state got %0d want 3", state); end
        for (int j = 1; j <= 2; j++) begin
            tick();
            n_cmp++; if (ce !== 2'b00 || step_done !== 1'b0 || state !== 2'd3) begin n_fail++; $display("FAIL step_wait %0d got ce=%b sd=%b st=%0d", j, ce, step_done, state); end
        end
        tick();
        n_cmp++; if (ce !== 2'b01 || step_done !== 1'b1) begin n_fail++; $display("FAIL step_fire got ce=%b sd=%b want 01/1", ce, step_done); end
        n_cmp++; if (state !== 2'd1) begin n_fail++; $display("FAIL step_back got %0d want 1", state); end
        n_cmp++; if (cyc_cnt !== 32'd45) begin n_fail++; $display("FAIL step_cyc got %0d want 45", cyc_cnt); end
        tick();
        n_cmp++; if (ce !== 2'b00 || step_done !== 1'b0) begin n_fail++; $display("FAIL step_after got ce=%b sd=%b want 00/0", ce, step_done); end
    endtask

    task automatic test_collisions();
        cmd_run = 1'b1; cmd_step = 1'b1; tick(); cmd_run = 1'b0; cmd_step = 1'b0;
        n_cmp++; if (state !== 2'd2) begin n_fail++; $display("FAIL col_run_step got %0d want 2", state); end
        cmd_run = 1'b1; cmd_halt = 1'b1; tick(); cmd_run = 1'b0; cmd_halt = 1'b0;
        n_cmp++; if (state !== 2'd1 || ce !== 2'b00) begin n_fail++; $display("FAIL col_run_halt got st=%0d ce=%b want 1/00", state, ce); end
        div = {8'd5, 8'd0};
        cmd_run = 1'b1; tick(); cmd_run = 1'b0;
        tick();
        n_cmp++; if (ce !== 2'b01) begin n_fail++; $display("FAIL col_pre got %b want 01", ce); end
        div = {8'd1, 8'd0};
        for (int j = 0; j < 4; j++) begin
            tick();
            n_cmp++; if (ce[1] !== (j % 2 == 0)) begin n_fail++; $display("FAIL col_shrink %0d got %b want %b", j, ce[1], (j % 2 == 0)); end
        end
        cmd_halt = 1'b1; tick(); cmd_halt = 1'b0;
        n_cmp++; if (cyc_cnt !== 32'd50) begin n_fail++; $display("FAIL col_cyc got %0d want 50", cyc_cnt); end
    endtask

    task automatic test_rst_mid();
        cmd_run = 1'b1; tick(); cmd_run = 1'b0;
        tick();
        RST = 1'b1; #1;
        n_cmp++; if (state !== 2'd0 || cpu_rst !== 1'b1) begin n_fail++; $display("FAIL mid_rst got st=%0d cr=%b want 0/1", state, cpu_rst); end
        n_cmp++; if (ce !== 2'b00 || cyc_cnt !== 32'd0) begin n_fail++; $display("FAIL mid_rst_out got ce=%b cyc=%0d want 00/0", ce, cyc_cnt); end
        tick();
        RST = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            tick();
            n_cmp++; if (cpu_rst !== (i < 16)) begin n_fail++; $display("FAIL mid_hold edge %0d got %b want %b", i, cpu_rst, (i < 16)); end
        end
        n_cmp++; if (state !== 2'd1) begin n_fail++; $display("FAIL mid_state got %0d want 1", state); end
    endtask

    task automatic test_break();
        brk_val = 32'd10;
        div = {8'd3, 8'd0};
        cmd_run = 1'b1; tick(); cmd_run = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            n_cmp++; if (ce[0] !== 1'b1) begin n_fail++; $display("FAIL brk_ce0 cycle %0d got %b want 1", i, ce[0]); end
        end
        n_cmp++; if (state !== (BRK ? 2'd1 : 2'd2)) begin n_fail++; $display("FAIL brk_state got %0d want %0d", state, (BRK ? 1 : 2)); end
        n_cmp++; if (brk_hit !== BRK) begin n_fail++; $display("FAIL brk_hit got %b want %b", brk_hit, BRK); end
        tick();
        n_cmp++; if (ce[0] !== !BRK) begin n_fail++; $display("FAIL brk_after got %b want %b", ce[0], !BRK); end
        n_cmp++; if (cyc_cnt !== (BRK ? 32'd10 : 32'd11)) begin n_fail++; $display("FAIL brk_cyc got %0d want %0d", cyc_cnt, (BRK ? 10 : 11)); end
        cmd_run = 1'b1; tick(); cmd_run = 1'b0;
        n_cmp++; if (brk_hit !== 1'b0 || state !== 2'd2) begin n_fail++; $display("FAIL brk_clear got hit=%b st=%0d want 0/2", brk_hit, state); end
        cmd_halt = 1'b1; tick(); cmd_halt = 1'b0;
    endtask

    initial begin
        test_reset();
        test_divide();
        test_halt_resume();
        test_step();
        test_collisions();
        test_rst_mid();
        test_break();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_clk_ctrl.md
Name: cpu_clk_ctrl

Overview:
- Parametrised clock-enable and reset sequencer for the CPU top; replaces free-running clock drive of the CPU core.
- Generates a held CPU reset, then N_CH divided clock-enable pulse channels under run/halt/single-step control.
- Counts executed cycles on channel 0.
- Sits between the board clock and the CPU top (datapath, memories and peripherals take one ce each).

Parameters:
- N_CH, 2, number of clock-enable channels (>=1).
- DIV_W, 8, width of each per-channel divide ratio.
- RST_CYC, 16, cycles cpu_rst stays high after RST deasserts (>=1).
- CNT_W, 32, width of cycle counter.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- cmd_run  in  1  single-cycle pulse: start free-running.
- cmd_halt  in  1  single-cycle pulse: stop.
- cmd_step  in  1  single-cycle pulse: advance one channel-0 cycle.
- div  in  N_CH*DIV_W  channel i ratio at [i*DIV_W +: DIV_W]; period = div_i+1 cycles.
- brk_val  in  CNT_W  breakpoint cycle count (feature only).
- ce  out  N_CH  registered one-cycle enable pulses.
- cpu_rst  out  1  registered reset to CPU, active-high.
- state  out  2  current FSM state encoding.
- step_done  out  1  one-cycle pulse when a step completes.
- cyc_cnt  out  CNT_W  number of ce[0] pulses issued.
- brk_hit  out  1  sticky breakpoint flag (feature only).

Behaviour:
- Reset (RST high, async): state=S_RST(0), cpu_rst=1, ce=0, step_done=0, cyc_cnt=0, brk_hit=0, all dividers d_i=0, reset counter=0.
- S_RST: counts clocks after RST falls. cpu_rst drops on the edge completing RST_CYC cycles; same edge -> S_HALT(1). All commands ignored.
- S_HALT: ce=0, dividers hold.
  - cmd_run -> S_RUN(2).
  - cmd_step -> S_STEP(3).
  - cmd_run and cmd_step together -> S_RUN.
- Dividers advance only in S_RUN/S_STEP.
  - Each edge: if d_i >= div_i then d_i<=0 and ce_i<=1, else d_i<=d_i+1 and ce_i<=0.
  - The >= compare handles a div shrinking below the current d_i: one pulse, then restart.
  - div_i=0 gives ce_i high every cycle.
- Latency: cmd_run sampled at edge k with d_i=0, div_i=0 -> state=S_RUN after edge k, ce_i high after edge k+1.
- S_RUN: cmd_halt -> S_HALT on next edge; no ce asserted after that edge; d_i retained so phase resumes. cmd_halt beats cmd_run. cmd_step ignored.
- S_STEP: dividers run until the edge that asserts ce[0]; the same edge -> S_HALT and asserts step_done (one cycle, coincident with the final ce[0]). Other channels pulse normally in between.
  - cmd_halt in S_STEP aborts -> S_HALT, no step_done.
  - cmd_run in S_STEP -> S_RUN.
- cyc_cnt increments on every edge asserting ce[0]; wraps at 2^CNT_W modulo; cleared only by RST.
- RST mid-operation: immediate return to reset values, including cpu_rst=1; the full RST_CYC hold is repeated.

Optional Feature:
- Macro CPU_CLK_BRK_EN.
- Defined:
  - On the edge asserting ce[0] where cyc_cnt+1 == brk_val, FSM -> S_HALT on that same edge (that pulse is issued) and brk_hit<=1.
  - brk_hit clears on accepted cmd_run or cmd_step.
  - brk_val=0 never matches until wrap.
  - A breakpoint in S_STEP also asserts step_done.
- Undefined: brk_val ignored, brk_hit tied 0, no compare logic.

Decomposition:
- Package cpu_clk_pkg: state encodings S_RST=2'd0, S_HALT=2'd1, S_RUN=2'd2, S_STEP=2'd3, plus the state_t typedef.
- One sub-module clk_div_ch: single-channel divider with inputs CLK, RST, adv, div_i and outputs ce_o, d_o. Instantiated N_CH times by generate.
- FSM, reset counter, cyc_cnt and breakpoint logic live in the top.

Test Plan:
- Reset hold: RST high 3 cycles then low, RST_CYC=16 -> cpu_rst high exactly 16 edges after RST falls; state goes 0->1; ce=0 throughout.
- Divide: div0=0, div1=3, cmd_run -> ce[0] every cycle; ce[1] every 4th cycle; after 40 cycles cyc_cnt=39.
- Halt/resume phase: div1=3, halt when d1=2 -> no ce for 10 cycles; after cmd_run, ce[1] pulses on the 2nd edge after entering S_RUN.
- Step: div0=2 from S_HALT, cmd_step -> exactly one ce[0] and coincident step_done 3 edges later; state back to 1; cyc_cnt+1.
- Collisions: cmd_run+cmd_step in HALT -> S_RUN; cmd_run+cmd_halt in RUN -> S_HALT; div1 reduced 5->1 while d1=4 -> one ce[1] next edge, then period 2.
- Break (CPU_CLK_BRK_EN): brk_val=10, div0=0, cmd_run -> 10 ce[0] pulses, halt, brk_hit=1; cmd_run clears brk_hit. Without macro: runs on, brk_hit=0.
